// File: rtl/rv32i_mem_arbiter_if.sv
// Bus bundle between the fetch/MEM requesters, the memory port and the rv32i_mem_arbiter.
// slave: arbiter side; master: the environment driving requests and memory responses.
interface rv32i_mem_arbiter_if #(
    parameter int unsigned MAX_OUTSTANDING = 2
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic             if_req_i;
    logic [31:0]      if_addr_i;
    logic             if_gnt_o;
    logic             if_rvalid_o;
    logic [31:0]      if_rdata_o;

    logic             dm_req_i;
    logic             dm_we_i;
    logic [3:0]       dm_be_i;
    logic [31:0]      dm_addr_i;
    logic [31:0]      dm_wdata_i;
    logic             dm_gnt_o;
    logic             dm_rvalid_o;
    logic [31:0]      dm_rdata_o;

    logic             mem_req_o;
    logic             mem_we_o;
    logic [3:0]       mem_be_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic             mem_gnt_i;
    logic             mem_rvalid_i;
    logic [31:0]      mem_rdata_i;

    logic [CNT_W-1:0] outstanding_o;
    logic             resp_err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output outstanding_o, resp_err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  outstanding_o, resp_err_o
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Fetch vs. load/store arbiter for one memory port, with an in-order source-tag FIFO for read routing.
// Define RV32I_MEM_ARB_DATA_PRIO_EN for fixed data-over-fetch priority instead of round-robin.
module rv32i_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rv32i_mem_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic [1:0] {LK_NONE, LK_IF, LK_DM} lock_e;

    lock_e                      lock_q, lock_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
    logic                       err_q, err_d;
`ifdef RV32I_MEM_ARB_DATA_PRIO_EN
`else
    logic                       last_q, last_d;
`endif

    logic full, empty, if_elig, dm_elig;
    logic sel_valid, sel_dm, accept, push, pop, head;

    // Selection, mux, tag FIFO and lock next-state
    always_comb begin
        full      = (cnt_q >= CNT_W'(MAX_OUTSTANDING));
        empty     = (cnt_q == '0);
        if_elig   = bus.if_req_i && !full;
        dm_elig   = bus.dm_req_i && (bus.dm_we_i || !full);
        sel_valid = 1'b0;
        sel_dm    = 1'b0;
        lock_d    = LK_NONE;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tag_d     = tag_q;
        err_d     = err_q;
`ifdef RV32I_MEM_ARB_DATA_PRIO_EN
`else
        last_d    = last_q;
`endif

        // A stalled request keeps its source until accepted or withdrawn
        if (lock_q == LK_IF && bus.if_req_i) begin
            sel_valid = 1'b1;
            sel_dm    = 1'b0;
        end else if (lock_q == LK_DM && bus.dm_req_i) begin
            sel_valid = 1'b1;
            sel_dm    = 1'b1;
        end else if (if_elig && dm_elig) begin
            sel_valid = 1'b1;
`ifdef RV32I_MEM_ARB_DATA_PRIO_EN
            sel_dm    = 1'b1;
`else
            sel_dm    = !last_q;
`endif
        end else if (if_elig) begin
            sel_valid = 1'b1;
            sel_dm    = 1'b0;
        end else if (dm_elig) begin
            sel_valid = 1'b1;
            sel_dm    = 1'b1;
        end

        accept = sel_valid && bus.mem_gnt_i;
        push   = accept && (!sel_dm || !bus.dm_we_i);
        pop    = bus.mem_rvalid_i && !empty;
        head   = tag_q[rd_ptr_q];

        if (sel_valid && !bus.mem_gnt_i) begin
            lock_d = sel_dm ? LK_DM : LK_IF;
        end
`ifdef RV32I_MEM_ARB_DATA_PRIO_EN
`else
        if (accept) begin
            last_d = sel_dm;
        end
`endif

        if (push) begin
            tag_d[wr_ptr_q] = sel_dm;
            wr_ptr_d = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        if (bus.mem_rvalid_i && empty) begin
            err_d = 1'b1;
        end

        bus.if_gnt_o    = accept && !sel_dm;
        bus.dm_gnt_o    = accept && sel_dm;
        bus.mem_req_o   = sel_valid;
        bus.mem_we_o    = sel_valid && sel_dm && bus.dm_we_i;
        bus.mem_be_o    = !sel_valid ? 4'h0 : (sel_dm ? bus.dm_be_i : 4'hF);
        bus.mem_addr_o  = !sel_valid ? 32'h0 : (sel_dm ? bus.dm_addr_i : bus.if_addr_i);
        bus.mem_wdata_o = (sel_valid && sel_dm) ? bus.dm_wdata_i : 32'h0;

        bus.if_rvalid_o   = pop && !head;
        bus.dm_rvalid_o   = pop && head;
        bus.if_rdata_o    = bus.mem_rdata_i;
        bus.dm_rdata_o    = bus.mem_rdata_i;
        bus.outstanding_o = cnt_q;
        bus.resp_err_o    = err_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q   <= LK_NONE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
`ifdef RV32I_MEM_ARB_DATA_PRIO_EN
`else
            last_q   <= 1'b1;
`endif
        end else begin
            lock_q   <= lock_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
`ifdef RV32I_MEM_ARB_DATA_PRIO_EN
`else
            last_q   <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed self-checking bench for rv32i_mem_arbiter (MAX_OUTSTANDING=2).
module tb_rv32i_mem_arbiter;
`ifdef RV32I_MEM_ARB_DATA_PRIO_EN
    localparam logic PRIO = 1'b1;
`else
    localparam logic PRIO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rv32i_mem_arbiter_if #(.MAX_OUTSTANDING(2)) bus ();

    rv32i_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = 32'h0;
        bus.dm_req_i     = 1'b0;
        bus.dm_we_i      = 1'b0;
        bus.dm_be_i      = 4'h0;
        bus.dm_addr_i    = 32'h0;
        bus.dm_wdata_i   = 32'h0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_outstanding", 32'(bus.outstanding_o), 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err_o), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
        chk("rst_if_gnt", 32'(bus.if_gnt_o), 32'd0);
        tick();

        // Simultaneous reads until the FIFO fills
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100;
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h200;
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("t1_c0_if_gnt", 32'(bus.if_gnt_o), 32'(!PRIO));
        chk("t1_c0_dm_gnt", 32'(bus.dm_gnt_o), 32'(PRIO));
        chk("t1_c0_addr", bus.mem_addr_o, PRIO ? 32'h200 : 32'h100);
        chk("t1_c0_be", 32'(bus.mem_be_o), 32'hF);
        tick();
        chk("t1_c1_outstanding", 32'(bus.outstanding_o), 32'd1);
        chk("t1_c1_dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
        chk("t1_c1_if_gnt", 32'(bus.if_gnt_o), 32'd0);
        chk("t1_c1_addr", bus.mem_addr_o, 32'h200);
        tick();
        chk("t1_c2_mem_req", 32'(bus.mem_req_o), 32'd0);
        chk("t1_c2_if_gnt", 32'(bus.if_gnt_o), 32'd0);
        chk("t1_c2_dm_gnt", 32'(bus.dm_gnt_o), 32'd0);
        chk("t1_c2_outstanding", 32'(bus.outstanding_o), 32'd2);

        // Write while full: still eligible, count unchanged
        bus.dm_we_i = 1'b1; bus.dm_be_i = 4'b0101; bus.dm_addr_i = 32'h300; bus.dm_wdata_i = 32'hDEAD_BEEF;
        #1;
        chk("t2_dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
        chk("t2_if_gnt", 32'(bus.if_gnt_o), 32'd0);
        chk("t2_we", 32'(bus.mem_we_o), 32'd1);
        chk("t2_be", 32'(bus.mem_be_o), 32'h5);
        chk("t2_wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
        tick();
        chk("t2_outstanding", 32'(bus.outstanding_o), 32'd2);

        // Drain: responses routed in issue order
        idle();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hAAAA_0000;
        #1;
        chk("t4_r0_if_rvalid", 32'(bus.if_rvalid_o), 32'(!PRIO));
        chk("t4_r0_dm_rvalid", 32'(bus.dm_rvalid_o), 32'(PRIO));
        chk("t4_r0_if_rdata", bus.if_rdata_o, 32'hAAAA_0000);
        tick();
        chk("t4_r0_outstanding", 32'(bus.outstanding_o), 32'd1);
        bus.mem_rdata_i = 32'h5555_1111;
        #1;
        chk("t4_r1_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        chk("t4_r1_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
        chk("t4_r1_dm_rdata", bus.dm_rdata_o, 32'h5555_1111);
        tick();
        chk("t4_outstanding", 32'(bus.outstanding_o), 32'd0);
        idle();

        // Stall with both requesting: selection locked for 3 cycles
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h400;
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h500;
        bus.mem_gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_lock_addr", bus.mem_addr_o, PRIO ? 32'h500 : 32'h400);
            chk("t3_lock_gnt", 32'({bus.if_gnt_o, bus.dm_gnt_o}), 32'd0);
            tick();
        end
        bus.mem_gnt_i = 1'b1;
        #1;
        chk("t3_rise_if_gnt", 32'(bus.if_gnt_o), 32'(!PRIO));
        chk("t3_rise_dm_gnt", 32'(bus.dm_gnt_o), 32'(PRIO));
        tick();
        if (PRIO) bus.dm_req_i = 1'b0; else bus.if_req_i = 1'b0;
        #1;
        chk("t3_next_if_gnt", 32'(bus.if_gnt_o), 32'(PRIO));
        chk("t3_next_dm_gnt", 32'(bus.dm_gnt_o), 32'(!PRIO));
        tick();
        chk("t3_outstanding", 32'(bus.outstanding_o), 32'd2);
        idle();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1;
        #1;
        chk("t3_r0_if_rvalid", 32'(bus.if_rvalid_o), 32'(!PRIO));
        tick();
        #1;
        chk("t3_r1_dm_rvalid", 32'(bus.dm_rvalid_o), 32'(!PRIO));
        chk("t3_r1_if_rvalid", 32'(bus.if_rvalid_o), 32'(PRIO));
        tick();
        chk("t3_drained", 32'(bus.outstanding_o), 32'd0);
        idle();

        // Push and pop in the same cycle
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h600; bus.mem_gnt_i = 1'b1;
        #1;
        chk("t5_if_gnt", 32'(bus.if_gnt_o), 32'd1);
        tick();
        chk("t5_outstanding1", 32'(bus.outstanding_o), 32'd1);
        idle();
        bus.dm_req_i = 1'b1; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h700; bus.mem_gnt_i = 1'b1;
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1234_5678;
        #1;
        chk("t5_dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
        chk("t5_if_rvalid", 32'(bus.if_rvalid_o), 32'd1);
        chk("t5_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd0);
        chk("t5_if_rdata", bus.if_rdata_o, 32'h1234_5678);
        tick();
        chk("t5_outstanding_same", 32'(bus.outstanding_o), 32'd1);
        idle();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h9;
        #1;
        chk("t5_head_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        chk("t5_head_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
        tick();
        chk("t5_outstanding0", 32'(bus.outstanding_o), 32'd0);
        idle();

        // Locked requester withdraws: data selected in the same cycle
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h800;
        #1;
        chk("t7_lock_addr", bus.mem_addr_o, 32'h800);
        tick();
        bus.if_req_i = 1'b0;
        bus.dm_req_i = 1'b1; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h900; bus.mem_gnt_i = 1'b1;
        #1;
        chk("t7_dm_gnt", 32'(bus.dm_gnt_o), 32'd1);
        chk("t7_addr", bus.mem_addr_o, 32'h900);
        tick();
        idle();
        bus.mem_rvalid_i = 1'b1;
        #1;
        chk("t7_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd1);
        tick();
        idle();

        // Reset with reads in flight, then a stale response
        bus.if_req_i = 1'b1; bus.mem_gnt_i = 1'b1;
        tick();
        idle();
        bus.dm_req_i = 1'b1; bus.dm_be_i = 4'hF; bus.mem_gnt_i = 1'b1;
        tick();
        chk("t6_outstanding2", 32'(bus.outstanding_o), 32'd2);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_outstanding", 32'(bus.outstanding_o), 32'd0);
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hBEEF;
        #1;
        chk("t6_if_rvalid", 32'(bus.if_rvalid_o), 32'd0);
        chk("t6_dm_rvalid", 32'(bus.dm_rvalid_o), 32'd0);
        tick();
        idle();
        chk("t6_resp_err", 32'(bus.resp_err_o), 32'd1);
        chk("t6_outstanding0", 32'(bus.outstanding_o), 32'd0);
        tick();
        chk("t6_resp_err_sticky", 32'(bus.resp_err_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rv32i_mem_arbiter.md
# rv32i_mem_arbiter

Shares one data-memory bus between the instruction-fetch requester and the load/store (MEM stage) requester. It grants one request per cycle. The source of every accepted read is recorded in an in-order tag FIFO, and each memory read response is routed back to the requester that issued it. The block sits between the core's fetch/MEM stages and the single-ported memory interface.

## Interface
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered reads; power of two, ≥1.
- clk_i  in  1  core clock.
- rst_i  in  1  reset; synchronous, active-high.
- if_req_i / if_addr_i  in  1 / 32  fetch read request and address; fetch never writes.
- if_gnt_o  out  1  fetch request accepted this cycle.
- if_rvalid_o / if_rdata_o  out  1 / 32  fetch read response.
- dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i  in  1,1,4,32,32  data request; fields as for the memory bus.
- dm_gnt_o  out  1  data request accepted this cycle.
- dm_rvalid_o / dm_rdata_o  out  1 / 32  data load response.
- mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1,1,4,32,32  muxed memory request.
- mem_gnt_i  in  1  memory accepts mem_req_o this cycle.
- mem_rvalid_i / mem_rdata_i  in  1 / 32  memory read response. Responses are in order; writes produce none.
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  reads in flight.
- resp_err_o  out  1  sticky: a response arrived with the FIFO empty.

## Operation
- Accept condition: mem_req_o && mem_gnt_i. The accepted requester sees its gnt high in that cycle; the other requester's gnt stays low.
- Eligibility:
  - Data write: always eligible.
  - Any read (fetch, or data with dm_we_i=0): eligible only while outstanding_o < MAX_OUTSTANDING.
  - The full check uses the registered count only. A pop in the same cycle does not unblock a read.
- Selection among eligible requesters:
  - Round-robin using a 1-bit last-winner pointer.
  - The pointer updates only on accept.
  - If only one requester is eligible, it wins.
- Lock:
  - If mem_req_o is high and mem_gnt_i is low, the selected source is held in the next cycle. Requesters keep their request stable.
  - The lock clears on accept.
  - If the locked requester drops its req, the lock releases and normal selection resumes that cycle.
- Mux: mem_* carries the winner's fields. A fetch drives we=0, be=4'b1111. With no winner, all mem_* are 0.
- Tag FIFO:
  - An accepted read pushes a source tag (0=fetch, 1=data).
  - mem_rvalid_i pops the head.
  - Push and pop in the same cycle are both performed; the count is unchanged.
- Routing:
  - if_rvalid_o = mem_rvalid_i && head==0; dm_rvalid_o = mem_rvalid_i && head==1.
  - Both rdata outputs are mem_rdata_i, unmasked.
- Empty-FIFO response: mem_rvalid_i while outstanding_o==0 is dropped. Neither rvalid is asserted, resp_err_o is set, and the count stays 0.
- Reset:
  - Clears the FIFO, count, pointer (next tie goes to fetch), lock and resp_err_o.
  - Responses to reads issued before reset therefore count as empty-FIFO responses and set resp_err_o.
  - resp_err_o clears only on reset.

## Timing
- Request path is combinational. req → mem_req_o/gnt in the same cycle, no added latency.
- Response path is combinational. mem_rvalid_i → if/dm_rvalid_o in the same cycle.
- FIFO, count, pointer and lock update on the clock edge after the accept or response.
- Reset values: outstanding_o=0, resp_err_o=0. Combinational outputs are 0 while all inputs are idle.
- Count arithmetic is unsigned. A push while full cannot happen because of the eligibility rule. A pop while empty is clamped at 0 and flagged.

## Configuration
- RV32I_MEM_ARB_DATA_PRIO_EN:
  - Defined: fixed priority; an eligible data request always beats fetch. The round-robin pointer is not implemented. The lock rule still applies.
  - Undefined: round-robin as described above.

## Test plan
- Simultaneous reads, mem_gnt_i=1 every cycle, MAX_OUTSTANDING=2, no responses → cycle 0 grants fetch, cycle 1 grants data, cycle 2 grants neither; outstanding_o=2. With the macro defined, data is granted first.
- Data write with FIFO full (outstanding_o=2) → dm_gnt_o=1, mem_we_o=1, mem_be_o copied from dm_be_i, count stays 2.
- mem_gnt_i held 0 for 3 cycles while fetch is selected and data also requests → mem_addr_o stays at if_addr_i for all 3 cycles; fetch is granted when gnt rises; data is granted the next cycle.
- Fetch read then data read accepted; responses 0xAAAA_0000 then 0x5555_1111 → if_rvalid_o carries 0xAAAA_0000, then dm_rvalid_o carries 0x5555_1111; outstanding_o returns to 0.
- Same cycle: accept a read and a response arrives, with outstanding_o=1 → count stays 1, the correct requester gets the response, and the new tag becomes the head.
- rst_i asserted with 2 reads outstanding, then 1 response arrives → neither rvalid asserts, resp_err_o=1, outstanding_o=0.
